// File: rtl/fifo_uart_tx_ctrl_pkg.sv
// rtl/fifo_uart_tx_ctrl_pkg.sv - shared state encoding and sizing helpers for the UART TX drain controller
package fifo_uart_tx_ctrl_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int GAP_CYCLES_DEF  = 16;
    localparam int ACK_TIMEOUT_DEF = 64;
    localparam int CNT_WIDTH_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_POP       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_GAP       = 3'd6,
        ST_FLUSH     = 3'd7
    } state_e;

    // One counter serves both the ack timeout and the inter-frame gap, so size it for the larger.
    function automatic int ctr_width(input int gap_cycles, input int ack_timeout);
        int max_v;
        max_v = (gap_cycles > ack_timeout) ? gap_cycles : ack_timeout;
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/ctrl_down_counter.sv
// rtl/ctrl_down_counter.sv - loadable down-counter shared by the ack-timeout and gap phases
module ctrl_down_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over decrement; decrementing saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/fifo_uart_tx_ctrl.sv
// rtl/fifo_uart_tx_ctrl.sv - drains the byte FIFO into the UART transmitter one frame at a time
module fifo_uart_tx_ctrl
    import fifo_uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  ctrl_busy,
    output logic [CNT_WIDTH-1:0]  sent_count,
    output logic                  flush_done,
    output logic                  err_timeout
);

    localparam int               CTR_W    = ctr_width(GAP_CYCLES, ACK_TIMEOUT);
    localparam logic [CTR_W-1:0] ACK_LOAD = CTR_W'(ACK_TIMEOUT - 1);
    localparam logic [CTR_W-1:0] GAP_LOAD = CTR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [CNT_WIDTH-1:0]    sent_q, sent_d;
    logic                    err_q, err_d;
    logic                    flush_pending_q, flush_pending_d;

    logic                    ctr_load;
    logic [CTR_W-1:0]        ctr_load_val;
    logic                    ctr_dec;
    logic                    ctr_zero;

    ctrl_down_counter #(
        .WIDTH (CTR_W)
    ) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ctr_load),
        .load_val_i (ctr_load_val),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    always_comb begin
        state_d         = state_q;
        tx_data_d       = tx_data_q;
        sent_d          = sent_q;
        err_d           = err_q;
        flush_pending_d = flush_pending_q;
        ctr_load        = 1'b0;
        ctr_load_val    = '0;
        ctr_dec         = 1'b0;

        // A flush during a frame is deferred until the frame and its gap are over.
        if (flush && (state_q != ST_IDLE) && (state_q != ST_FLUSH)) begin
            flush_pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (flush || flush_pending_q) begin
                    state_d = ST_FLUSH;
                end else if (enable && !fifo_empty && !tx_busy) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_data_d = fifo_rd_data;
                state_d   = ST_START;
            end
            ST_START: begin
                ctr_load     = 1'b1;
                ctr_load_val = ACK_LOAD;
                state_d      = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ctr_zero) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    sent_d = sent_q + CNT_WIDTH'(1);
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        ctr_load     = 1'b1;
                        ctr_load_val = GAP_LOAD;
                        state_d      = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (ctr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (fifo_empty) begin
                    flush_pending_d = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            tx_data_q       <= '0;
            sent_q          <= '0;
            err_q           <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            tx_data_q       <= tx_data_d;
            sent_q          <= sent_d;
            err_q           <= err_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Flush drains combinationally so one entry leaves per clock until the FIFO reports empty.
    assign fifo_rd_en  = (state_q == ST_POP) || ((state_q == ST_FLUSH) && !fifo_empty);
    assign tx_start    = (state_q == ST_START);
    assign ctrl_busy   = (state_q != ST_IDLE);
    assign flush_done  = (state_q == ST_FLUSH) && fifo_empty;
    assign tx_data     = tx_data_q;
    assign sent_count  = sent_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_fifo_uart_tx_ctrl.sv
// tb/tb_fifo_uart_tx_ctrl.sv - self-checking bench for fifo_uart_tx_ctrl with FIFO and transmitter models
module tb_fifo_uart_tx_ctrl;

    localparam int DW   = 8;
    localparam int GAP0 = 16;
    localparam int ACK  = 64;
    localparam int CW   = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic          enable     [2];
    logic          flush      [2];
    logic          fifo_empty [2];
    logic          rd_en      [2];
    logic [DW-1:0] rd_data    [2];
    logic          tx_busy    [2];
    logic          tx_start   [2];
    logic [DW-1:0] tx_data    [2];
    logic          ctrl_busy  [2];
    logic [CW-1:0] sent_count [2];
    logic          flush_done [2];
    logic          err_timeout[2];

    always #5 clk = ~clk;

    fifo_uart_tx_ctrl #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP0), .ACK_TIMEOUT(ACK), .CNT_WIDTH(CW)) u_dut_gap (
        .clk(clk), .rst_n(rst_n), .enable(enable[0]), .flush(flush[0]), .fifo_empty(fifo_empty[0]),
        .fifo_rd_en(rd_en[0]), .fifo_rd_data(rd_data[0]), .tx_busy(tx_busy[0]), .tx_start(tx_start[0]),
        .tx_data(tx_data[0]), .ctrl_busy(ctrl_busy[0]), .sent_count(sent_count[0]),
        .flush_done(flush_done[0]), .err_timeout(err_timeout[0])
    );

    fifo_uart_tx_ctrl #(.DATA_WIDTH(DW), .GAP_CYCLES(0), .ACK_TIMEOUT(ACK), .CNT_WIDTH(CW)) u_dut_nogap (
        .clk(clk), .rst_n(rst_n), .enable(enable[1]), .flush(flush[1]), .fifo_empty(fifo_empty[1]),
        .fifo_rd_en(rd_en[1]), .fifo_rd_data(rd_data[1]), .tx_busy(tx_busy[1]), .tx_start(tx_start[1]),
        .tx_data(tx_data[1]), .ctrl_busy(ctrl_busy[1]), .sent_count(sent_count[1]),
        .flush_done(flush_done[1]), .err_timeout(err_timeout[1])
    );

    typedef struct {
        int         dut;
        int         nbytes;
        logic [7:0] base;
        int         flush_mode;   // 0 none, 1 while idle, 2 mid-frame
        int         dead;
        int         exp_starts;
        int         exp_sent;
        int         exp_rd;
        int         exp_fd;
        int         exp_err;
    } vec_t;

    int checks = 0;
    int failures = 0;

    int         sel;
    int         tick_n;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic [7:0] rd_data_m;
    logic       tx_busy_m;
    int         tx_rem;
    bit         ack_pend;
    int         ack_cnt;
    int         frame_len;
    int         ack_delay;
    bit         tx_dead;
    logic       en_v;
    logic       flush_req;

    logic       c_rd, c_start, c_fd, c_err, c_cbusy, prev_rd;
    logic [7:0] c_txd;
    logic [CW-1:0] c_sent;

    int n_rd, n_rd_rise, n_start, n_fd, n_done, n_underflow, n_start_busy, n_gap_short;
    int last_fall, last_start, last_rd, empty_fall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 0) ? GAP0 : 0;
    endfunction

    task automatic drive();
        if (fifo_empty[sel] === 1'b1 && fq.size() > 0) empty_fall = tick_n;
        for (int d = 0; d < 2; d++) begin
            enable[d]     = (d == sel) ? en_v : 1'b0;
            flush[d]      = (d == sel) ? flush_req : 1'b0;
            fifo_empty[d] = (d == sel) ? (fq.size() == 0) : 1'b1;
            tx_busy[d]    = (d == sel) ? tx_busy_m : 1'b0;
            rd_data[d]    = (d == sel) ? rd_data_m : '0;
        end
        flush_req = 1'b0;
    endtask

    task automatic capture();
        c_rd    = rd_en[sel];
        c_start = tx_start[sel];
        c_txd   = tx_data[sel];
        c_cbusy = ctrl_busy[sel];
        c_sent  = sent_count[sel];
        c_fd    = flush_done[sel];
        c_err   = err_timeout[sel];
        if (c_rd) begin
            n_rd++;
            last_rd = tick_n;
            if (!prev_rd) n_rd_rise++;
        end
        prev_rd = c_rd;
        if (c_fd) n_fd++;
        if (c_start) begin
            n_start++;
            if (tx_busy_m) n_start_busy++;
            if (last_fall >= 0 && (tick_n - last_fall) < gap_of(sel) + 4) n_gap_short++;
            last_start = tick_n;
            check("tx_byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("tx_byte_order", c_txd, exp_q.pop_front());
        end
    endtask

    // FIFO and transmitter react at the clock edge to what the controller showed during the previous cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        tick_n++;
        if (c_rd) begin
            if (fq.size() > 0) rd_data_m = fq.pop_front();
            else n_underflow++;
        end
        if (tx_busy_m) begin
            tx_rem--;
            if (tx_rem == 0) begin
                tx_busy_m = 1'b0;
                n_done++;
                last_fall = tick_n;
            end
        end
        if (c_start && !tx_dead) begin
            ack_pend = 1'b1;
            ack_cnt  = ack_delay;
        end
        if (ack_pend) begin
            if (ack_cnt == 0) begin
                tx_busy_m = 1'b1;
                tx_rem    = frame_len;
                ack_pend  = 1'b0;
            end else begin
                ack_cnt--;
            end
        end
        drive();
        @(negedge clk);
        capture();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fq.delete();
        exp_q.delete();
        tx_busy_m = 1'b0; tx_rem = 0; ack_pend = 1'b0; ack_cnt = 0; tx_dead = 1'b0;
        en_v = 1'b0; flush_req = 1'b0; rd_data_m = '0;
        c_rd = 1'b0; c_start = 1'b0; prev_rd = 1'b0;
        frame_len = 6; ack_delay = 1;
        drive();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_rd = 0; n_rd_rise = 0; n_start = 0; n_fd = 0; n_done = 0;
        n_underflow = 0; n_start_busy = 0; n_gap_short = 0;
        last_fall = -1; last_start = -1; last_rd = -1; empty_fall = -1;
        @(negedge clk);
        capture();
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int quiet = 0;
        int t = 0;
        while (quiet < 4 && t < budget) begin
            tick();
            t++;
            if (!c_cbusy && !tx_busy_m && !ack_pend && (fq.size() == 0 || !en_v)) quiet++;
            else quiet = 0;
        end
        check({name, "_settled"}, quiet >= 4, 1);
    endtask

    task automatic wait_for_busy(input string name, input int budget);
        int t = 0;
        while (!tx_busy_m && t < budget) begin
            tick();
            t++;
        end
        check({name, "_frame_started"}, tx_busy_m, 1);
    endtask

    vec_t vecs [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int s_tick;
        int err_tick;

        //         dut n  base  flush dead starts sent rd fd err
        vecs[0] = '{1, 3, 8'h01, 0,    0,   3,     3,   3, 0, 0};
        vecs[1] = '{0, 5, 8'h40, 1,    0,   0,     0,   5, 1, 0};
        vecs[2] = '{0, 5, 8'h60, 2,    0,   1,     1,   5, 1, 0};
        vecs[3] = '{1, 5, 8'h80, 2,    0,   1,     1,   5, 1, 0};
        vecs[4] = '{0, 1, 8'h9C, 0,    1,   1,     0,   1, 0, 1};
        vecs[5] = '{0, 4, 8'hB0, 0,    0,   4,     4,   4, 0, 0};
        vecs[6] = '{1, 4, 8'hD0, 0,    0,   4,     4,   4, 0, 0};

        rst_n = 1'b0;
        tick_n = 0;
        sel = 0;

        // Reset state of both instances, then first-byte latency and inter-frame gap.
        do_reset();
        for (int d = 0; d < 2; d++) begin
            check("rst_fifo_rd_en", rd_en[d], 0);
            check("rst_tx_start", tx_start[d], 0);
            check("rst_tx_data", tx_data[d], 0);
            check("rst_ctrl_busy", ctrl_busy[d], 0);
            check("rst_sent_count", sent_count[d], 0);
            check("rst_flush_done", flush_done[d], 0);
            check("rst_err_timeout", err_timeout[d], 0);
        end
        en_v = 1'b1; frame_len = 10; ack_delay = 0;
        push(8'hA5);
        t = 0;
        while (n_start < 1 && t < 30) begin tick(); t++; end
        check("lat_start_seen", n_start, 1);
        check("lat_empty_to_start", last_start - empty_fall, 3);
        check("lat_tx_data", c_txd, 8'hA5);
        push(8'h5A);
        t = 0;
        while (n_rd < 2 && t < 200) begin tick(); t++; end
        check("gap_second_pop_seen", n_rd, 2);
        // Busy low is seen on the next edge, then GAP0 gap cycles, one IDLE cycle, then POP.
        check("gap_fall_to_pop", last_rd - last_fall, GAP0 + 2);
        wait_idle("gap", 300);
        check("gap_sent_count", c_sent, 2);

        // Ack timeout, sticky error, recovery.
        sel = 0;
        do_reset();
        tx_dead = 1'b1; en_v = 1'b1;
        push(8'h3C);
        t = 0;
        while (n_start < 1 && t < 30) begin tick(); t++; end
        check("to_start_seen", n_start, 1);
        s_tick = last_start;
        t = 0;
        while (!c_err && t < 300) begin tick(); t++; end
        err_tick = tick_n;
        check("to_err_set", c_err, 1);
        // tx_start cycle plus ACK wait cycles: the error appears ACK edges after the start pulse ends.
        check("to_err_latency", err_tick - s_tick, ACK + 1);
        check("to_back_idle", c_cbusy, 0);
        check("to_sent_zero", c_sent, 0);
        tx_dead = 1'b0;
        push(8'hC3);
        wait_idle("to_recover", 300);
        check("to_recover_sent", c_sent, 1);
        check("to_recover_starts", n_start, 2);
        check("to_err_sticky", c_err, 1);

        // Asynchronous reset while a frame is on the wire.
        sel = 0;
        do_reset();
        en_v = 1'b1; frame_len = 5;
        push(8'h11);
        wait_idle("ar_first", 300);
        check("ar_first_sent", c_sent, 1);
        frame_len = 30;
        push(8'h77);
        wait_for_busy("ar", 40);
        repeat (3) tick();
        check("ar_mid_frame_busy", c_cbusy, 1);
        check("ar_mid_frame_data", c_txd, 8'h77);
        rst_n = 1'b0;
        #1;
        check("ar_rd_en", rd_en[0], 0);
        check("ar_tx_start", tx_start[0], 0);
        check("ar_tx_data", tx_data[0], 0);
        check("ar_ctrl_busy", ctrl_busy[0], 0);
        check("ar_sent_count", sent_count[0], 0);
        check("ar_flush_done", flush_done[0], 0);
        check("ar_err", err_timeout[0], 0);
        do_reset();
        repeat (5) tick();
        check("ar_after_idle", c_cbusy, 0);
        check("ar_after_sent", c_sent, 0);

        // Table of multi-byte, flush and timeout scenarios.
        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].dut;
            do_reset();
            tx_dead = (vecs[i].dead != 0);
            en_v = (vecs[i].flush_mode != 1);
            for (int k = 0; k < vecs[i].nbytes; k++) push(vecs[i].base + 8'(k));
            if (vecs[i].flush_mode == 1) flush_req = 1'b1;
            if (vecs[i].flush_mode == 2) begin
                wait_for_busy("vec", 40);
                flush_req = 1'b1;
            end
            wait_idle("vec", 600);
            check("vec_starts", n_start, vecs[i].exp_starts);
            check("vec_sent", c_sent, vecs[i].exp_sent);
            check("vec_rd_cycles", n_rd, vecs[i].exp_rd);
            check("vec_flush_done", n_fd, vecs[i].exp_fd);
            check("vec_err", c_err, vecs[i].exp_err);
            check("vec_underflow", n_underflow, 0);
            if (vecs[i].flush_mode == 0) check("vec_rd_pulses", n_rd_rise, vecs[i].exp_rd);
        end

        // Randomized traffic against the queue/timing model.
        for (int r = 0; r < 6; r++) begin
            sel = r % 2;
            do_reset();
            en_v = 1'b1;
            for (int k = 0; k < 500; k++) begin
                frame_len = $urandom_range(1, 12);
                ack_delay = $urandom_range(0, 3);
                if ($urandom_range(0, 5) == 0 && fq.size() < 8) push(8'($urandom));
                if ($urandom_range(0, 39) == 0) en_v = ~en_v;
                tick();
            end
            en_v = 1'b1;
            wait_idle("rand", 3000);
            check("rand_all_sent", exp_q.size(), 0);
            check("rand_sent_count", c_sent, CW'(n_done));
            check("rand_starts", n_start, n_done);
            check("rand_underflow", n_underflow, 0);
            check("rand_start_while_busy", n_start_busy, 0);
            check("rand_gap_short", n_gap_short, 0);
            check("rand_err", c_err, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
